// File: rtl/apb_mem_responder.sv
// APB completer backed by a word-addressed register-file memory.
// Inserts WAIT_STATES PReady-low cycles in the access phase and answers
// accesses at or beyond DEPTH with PSlvErr (no write, read data of zero).
// The storage array is named memory[] so checkers can peek at it.
module apb_mem_responder #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              PSel,
    input  logic              PEnable,
    input  logic              PWrite,
    input  logic [ADDR_W-1:0] PAddr,
    input  logic [DATA_W-1:0] PWData,
    output logic [DATA_W-1:0] PRData,
    output logic              PReady,
    output logic              PSlvErr
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]    addr_q, addr_d;
    logic                write_q, write_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [DATA_W-1:0]   memory [DEPTH];

    logic                in_range_s;
    logic                mem_we_s;

    // Word index is valid only below DEPTH; one extra bit avoids truncating DEPTH.
    assign in_range_s = ({1'b0, PAddr} < (ADDR_W + 1)'(DEPTH));

    // Read data is a register: it only changes when a read is set up or on reset.
    assign PRData = rdata_q;

    // Next-state, transfer capture and handshake outputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        mem_we_s = 1'b0;
        PReady   = 1'b0;
        PSlvErr  = 1'b0;
        case (state_q)
            IDLE: begin
                // Only a genuine setup phase starts a transfer; an access
                // strobe without a preceding setup is ignored.
                if (PSel && !PEnable) begin
                    addr_d  = PAddr[IDX_W-1:0];
                    write_d = PWrite;
                    wdata_d = PWData;
                    err_d   = !in_range_s;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = ACCESS;
                    if (!PWrite) begin
                        if (in_range_s) begin
                            rdata_d = memory[PAddr[IDX_W-1:0]];
                        end else begin
                            rdata_d = '0;
                        end
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                PReady  = (cnt_q == 4'd0);
                PSlvErr = err_q && (cnt_q == 4'd0);
                if (PSel && PEnable) begin
                    if (cnt_q == 4'd0) begin
                        mem_we_s = write_q && !err_q;
                        state_d  = IDLE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end else begin
                    // Initiator withdrew mid-transfer: abandon without writing.
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and captured-transfer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Memory is never cleared; a reset edge suppresses an in-flight write.
    always_ff @(posedge clk) begin
        if (mem_we_s && !Rst) begin
            memory[addr_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_apb_mem_responder.sv
// Directed bench for apb_mem_responder. Three instances share the clock and
// differ only in WAIT_STATES (0, 3, 2). Expected responses are queued when a
// transfer is driven and compared when the responder raises PReady.
module tb_apb_mem_responder;

    logic        clk;
    logic        rst     [3];
    logic        psel    [3];
    logic        pen     [3];
    logic        pwr     [3];
    logic [15:0] paddr   [3];
    logic [31:0] pwdata  [3];
    logic [31:0] prdata  [3];
    logic        pready  [3];
    logic        pslverr [3];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          waits;
        bit          is_read;
    } exp_t;

    exp_t        sb_q [$];
    logic [31:0] model_mem [3][256];
    bit          known     [3][256];
    int          n_pass;
    int          n_total;

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 3 : 2);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        apb_mem_responder #(
            .ADDR_W      (16),
            .DATA_W      (32),
            .DEPTH       (256),
            .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 3 : 2))
        ) u_dut (
            .clk     (clk),
            .Rst     (rst[g]),
            .PSel    (psel[g]),
            .PEnable (pen[g]),
            .PWrite  (pwr[g]),
            .PAddr   (paddr[g]),
            .PWData  (pwdata[g]),
            .PRData  (prdata[g]),
            .PReady  (pready[g]),
            .PSlvErr (pslverr[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] peek(input int d, input logic [7:0] ix);
        case (d)
            0:       return gen_dut[0].u_dut.memory[ix];
            1:       return gen_dut[1].u_dut.memory[ix];
            default: return gen_dut[2].u_dut.memory[ix];
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    endtask

    // One APB transfer on instance d; starts and ends just after a falling edge.
    task automatic xfer(input int d, input bit wr, input logic [15:0] a,
                        input logic [31:0] wd, input bit keep_sel);
        exp_t       e;
        int         waits;
        logic [7:0] ix;
        bit         inr;
        ix        = a[7:0];
        inr       = (a < 16'd256);
        e.err     = !inr;
        e.waits   = ws_of(d);
        e.is_read = !wr;
        e.rdata   = (!wr && inr) ? model_mem[d][ix] : 32'h0;
        sb_q.push_back(e);
        psel[d]   = 1'b1;
        pen[d]    = 1'b0;
        pwr[d]    = wr;
        paddr[d]  = a;
        pwdata[d] = wd;
        @(negedge clk);
        pen[d]    = 1'b1;
        paddr[d]  = ~a;
        pwdata[d] = ~wd;
        waits     = 0;
        while (pready[d] !== 1'b1 && waits < 40) begin
            if (wr && known[d][ix]) check("mem_early", peek(d, ix), model_mem[d][ix]);
            @(negedge clk);
            waits++;
        end
        e = sb_q.pop_front();
        check("pready", {31'd0, pready[d]}, 32'd1);
        check("wait_cycles", 32'(waits), 32'(e.waits));
        check("pslverr", {31'd0, pslverr[d]}, {31'd0, e.err});
        if (e.is_read) check("prdata", prdata[d], e.rdata);
        if (wr && known[d][ix]) check("mem_pre", peek(d, ix), model_mem[d][ix]);
        @(negedge clk);
        if (wr && inr) begin
            model_mem[d][ix] = wd;
            known[d][ix]     = 1'b1;
        end
        if (known[d][ix]) check("mem_post", peek(d, ix), model_mem[d][ix]);
        check("pready_idle", {31'd0, pready[d]}, 32'd0);
        pen[d] = 1'b0;
        if (!keep_sel) psel[d] = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_pass  = 0;
        n_total = 0;
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; psel[d] = 1'b0; pen[d] = 1'b0; pwr[d] = 1'b0;
            paddr[d] = 16'h0; pwdata[d] = 32'h0;
            for (int i = 0; i < 256; i++) begin
                known[d][i]     = 1'b0;
                model_mem[d][i] = 32'h0;
            end
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("rst_pready", {31'd0, pready[d]}, 32'd0);
            check("rst_pslverr", {31'd0, pslverr[d]}, 32'd0);
            check("rst_prdata", prdata[d], 32'h0);
            rst[d] = 1'b0;
        end
        @(negedge clk);

        // Zero wait states: write, read-back, out-of-range, back-to-back.
        xfer(0, 1'b1, 16'h0050, 32'h0000_0050, 1'b0);
        xfer(0, 1'b0, 16'h0050, 32'h0,         1'b0);
        xfer(0, 1'b1, 16'h0000, 32'h00C0_FFEE, 1'b0);
        xfer(0, 1'b1, 16'h0100, 32'h0000_0001, 1'b0);
        xfer(0, 1'b0, 16'h0100, 32'h0,         1'b0);
        xfer(0, 1'b1, 16'h0001, 32'h0000_000A, 1'b1);
        xfer(0, 1'b0, 16'h0001, 32'h0,         1'b0);
        xfer(0, 1'b0, 16'h0000, 32'h0,         1'b0);

        // Three wait states: memory changes only on the completion edge.
        xfer(1, 1'b1, 16'h0010, 32'h0000_1111, 1'b0);
        xfer(1, 1'b1, 16'h0010, 32'hDEAD_BEEF, 1'b0);
        xfer(1, 1'b0, 16'h0010, 32'h0,         1'b0);

        // Two wait states: reset during an access phase drops the write.
        xfer(2, 1'b1, 16'h0020, 32'h0000_0077, 1'b0);
        xfer(2, 1'b0, 16'h0020, 32'h0,         1'b0);
        psel[2] = 1'b1; pen[2] = 1'b0; pwr[2] = 1'b1;
        paddr[2] = 16'h0020; pwdata[2] = 32'h0000_0005;
        @(negedge clk);
        pen[2] = 1'b1;
        check("rst6_waiting", {31'd0, pready[2]}, 32'd0);
        rst[2] = 1'b1;
        @(negedge clk);
        rst[2] = 1'b0; psel[2] = 1'b0; pen[2] = 1'b0;
        check("rst6_pready", {31'd0, pready[2]}, 32'd0);
        check("rst6_prdata", prdata[2], 32'h0);
        check("rst6_pslverr", {31'd0, pslverr[2]}, 32'd0);
        check("rst6_mem", peek(2, 8'h20), 32'h0000_0077);
        @(negedge clk);
        check("rst6_mem_later", peek(2, 8'h20), 32'h0000_0077);
        xfer(2, 1'b0, 16'h0020, 32'h0,         1'b0);
        xfer(2, 1'b1, 16'h0021, 32'h0000_0005, 1'b0);
        xfer(2, 1'b0, 16'h0021, 32'h0,         1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
